// File: rtl/ascii_write_buffer_pkg.sv
// Shared store-size codes, drain FSM states and size decoding for the ASCII write buffer.
package ascii_write_buffer_pkg;

  localparam logic [1:0] SIZE_NONE = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } drain_state_t;

  // Number of character beats a store of the given size expands into.
  function automatic logic [2:0] size_to_beats(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_to_beats = 3'd1;
      SIZE_HALF: size_to_beats = 3'd2;
      SIZE_WORD: size_to_beats = 3'd4;
      default:   size_to_beats = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ascii_write_buffer_if.sv
// Store-request and character-RAM write bus of the ASCII write buffer.
interface ascii_write_buffer_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_data;
  logic [1:0]        in_size;
  logic              char_ready;
  logic              char_we;
  logic [ADDR_W-1:0] char_addr;
  logic [7:0]        char_data;
  logic [CW-1:0]     count;
  logic              empty;
  logic              range_error;

  // Core / character-RAM side
  modport master (
    output in_valid, in_addr, in_data, in_size, char_ready,
    input  in_ready, char_we, char_addr, char_data, count, empty, range_error
  );

  // Buffer side
  modport slave (
    input  in_valid, in_addr, in_data, in_size, char_ready,
    output in_ready, char_we, char_addr, char_data, count, empty, range_error
  );
endinterface

// File: rtl/ascii_write_buffer_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot a same-cycle push may use, even when full.
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/ascii_write_buffer.sv
// Queues byte/half/word character stores and drains them one character per cycle.
module ascii_write_buffer
  import ascii_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned CHAR_COUNT = 4800
) (
  input  logic                 clk,
  input  logic                 rst,
  ascii_write_buffer_if.slave  bus
);
  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam int unsigned FIFO_W = ADDR_W + 32 + 2;

  drain_state_t      state_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       data_q;
  logic [2:0]        remaining_q;
  logic [1:0]        idx_q;
  logic              char_we_q;
  logic [ADDR_W-1:0] char_addr_q;
  logic [7:0]        char_data_q;
  logic              oor_q;
  logic              range_error_q;
  logic [CW-1:0]     count_q;
  logic              in_ready_q;
  logic              empty_q;

  logic [FIFO_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     unused_fifo_count;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_data;
  logic [1:0]        head_size;

  logic              push;
  logic              beat_done;
  logic              last_beat;
  logic              load;
  logic [1:0]        idx_nxt;
  logic [ADDR_W-1:0] nxt_addr;
  logic [7:0]        nxt_byte;
  logic              nxt_in_range;
  logic              head_in_range;
  logic [CW-1:0]     count_next;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < CHAR_COUNT;
  endfunction

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push && !fifo_full),
    .din   ({bus.in_addr, bus.in_data, bus.in_size}),
    .pop   (load),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  assign {head_addr, head_data, head_size} = fifo_dout;

  // Handshake, beat completion and next-beat address/byte selection.
  always_comb begin
    push          = bus.in_valid && in_ready_q && (bus.in_size != SIZE_NONE);
    beat_done     = (state_q == EMIT) && ((char_we_q && bus.char_ready) || oor_q);
    last_beat     = beat_done && (remaining_q == 3'd1);
    load          = !fifo_empty && ((state_q == IDLE) || last_beat);
    idx_nxt       = idx_q + 2'd1;
    nxt_addr      = base_q + ADDR_W'(idx_nxt);
    nxt_byte      = data_q[{idx_nxt, 3'b000} +: 8];
    nxt_in_range  = in_range(nxt_addr);
    head_in_range = in_range(head_addr);
    count_next    = count_q + CW'(push) - CW'(last_beat);
  end

  // Drain FSM with registered character-port outputs and occupancy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      data_q        <= '0;
      remaining_q   <= '0;
      idx_q         <= '0;
      char_we_q     <= 1'b0;
      char_addr_q   <= '0;
      char_data_q   <= '0;
      oor_q         <= 1'b0;
      range_error_q <= 1'b0;
      count_q       <= '0;
      in_ready_q    <= 1'b1;
      empty_q       <= 1'b1;
    end else begin
      count_q    <= count_next;
      in_ready_q <= (32'(count_next) < DEPTH);
      empty_q    <= (count_next == '0);
      if (load) begin
        state_q     <= EMIT;
        base_q      <= head_addr;
        data_q      <= head_data;
        remaining_q <= size_to_beats(head_size);
        idx_q       <= '0;
        char_addr_q <= head_addr;
        char_data_q <= head_data[7:0];
        char_we_q   <= head_in_range;
        oor_q       <= !head_in_range;
        if (!head_in_range) range_error_q <= 1'b1;
      end else if (last_beat) begin
        state_q   <= IDLE;
        char_we_q <= 1'b0;
        oor_q     <= 1'b0;
      end else if (beat_done) begin
        idx_q       <= idx_nxt;
        remaining_q <= remaining_q - 3'd1;
        char_addr_q <= nxt_addr;
        char_data_q <= nxt_byte;
        char_we_q   <= nxt_in_range;
        oor_q       <= !nxt_in_range;
        if (!nxt_in_range) range_error_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.char_we     = char_we_q;
  assign bus.char_addr   = char_addr_q;
  assign bus.char_data   = char_data_q;
  assign bus.count       = count_q;
  assign bus.empty       = empty_q;
  assign bus.range_error = range_error_q;

endmodule

// File: tb/tb_ascii_write_buffer.sv
// Scoreboard bench for ascii_write_buffer.
module tb_ascii_write_buffer;
  import ascii_write_buffer_pkg::*;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } beat_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  beat_t exp_q[$];
  logic  exp_range_err;
  beat_t mon_b;

  ascii_write_buffer_if #(.ADDR_W(13), .DEPTH(8)) bus();

  ascii_write_buffer #(
    .DEPTH      (8),
    .ADDR_W     (13),
    .CHAR_COUNT (4800)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Every completed character write must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && bus.char_we && bus.char_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                 bus.char_addr, bus.char_data);
      end else begin
        mon_b = exp_q.pop_front();
        if (bus.char_addr !== mon_b.addr || bus.char_data !== mon_b.data) begin
          bad++;
          $display("FAIL char_write: got addr=%h data=%h, required addr=%h data=%h",
                   bus.char_addr, bus.char_data, mon_b.addr, mon_b.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected character beats of a store into the scoreboard.
  task automatic expect_store(input logic [12:0] addr, input logic [31:0] data,
                              input logic [1:0] size);
    int n;
    logic [12:0] a;
    logic [31:0] d;
    n = (size == SIZE_BYTE) ? 1 : (size == SIZE_HALF) ? 2 : (size == SIZE_WORD) ? 4 : 0;
    d = data;
    for (int i = 0; i < n; i++) begin
      a = addr + 13'(i);
      if (a < 13'd4800) exp_q.push_back({a, d[8*i +: 8]});
      else exp_range_err = 1'b1;
    end
  endtask

  task automatic push_store(input logic [12:0] addr, input logic [31:0] data,
                            input logic [1:0] size);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (!bus.in_ready) begin
      bad++;
      $display("FAIL push_wait: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_addr  = addr;
    bus.in_data  = data;
    bus.in_size  = size;
    expect_store(addr, data, size);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.empty) && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || !bus.empty) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d empty=%b, required pending=0 empty=1",
               exp_q.size(), bus.empty);
    end
    total++;
    if (bus.count !== 4'd0 || bus.char_we !== 1'b0) begin
      bad++;
      $display("FAIL drain_idle: count=%0d char_we=%b, required count=0 char_we=0",
               bus.count, bus.char_we);
    end
  endtask

  task automatic check_reset_state(input string tag);
    total++;
    if (bus.char_we !== 1'b0 || bus.count !== 4'd0 || bus.empty !== 1'b1 ||
        bus.in_ready !== 1'b1 || bus.range_error !== 1'b0) begin
      bad++;
      $display("FAIL %s: we=%b count=%0d empty=%b in_ready=%b range_error=%b, required 0/0/1/1/0",
               tag, bus.char_we, bus.count, bus.empty, bus.in_ready, bus.range_error);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    exp_q.delete();
    exp_range_err = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_state("reset_initial");
    bus.char_ready = 1'b1;
    push_store(13'h0020, 32'h34333231, SIZE_WORD);
    tick();
    tick();
    apply_reset();
    check_reset_state("reset_mid_drain");
    tick();
    tick();
    check_reset_state("reset_no_resume");
  endtask

  task automatic test_single_word();
    bus.char_ready = 1'b1;
    push_store(13'h0010, 32'h44434241, SIZE_WORD);
    total++;
    if (bus.char_we !== 1'b0 || bus.count !== 4'd1 || bus.empty !== 1'b0) begin
      bad++;
      $display("FAIL single_accept: we=%b count=%0d empty=%b, required 0/1/0",
               bus.char_we, bus.count, bus.empty);
    end
    tick();
    total++;
    if (bus.char_we !== 1'b1 || bus.char_addr !== 13'h0010 || bus.char_data !== 8'h41) begin
      bad++;
      $display("FAIL single_first_beat: we=%b addr=%h data=%h, required 1/0010/41",
               bus.char_we, bus.char_addr, bus.char_data);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    bus.char_ready = 1'b0;
    push_store(13'h0000, 32'h00000048, SIZE_BYTE);
    push_store(13'h0001, 32'h00006F69, SIZE_HALF);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.char_we !== 1'b1 || bus.char_addr !== 13'h0000 || bus.char_data !== 8'h48) begin
        bad++;
        $display("FAIL stall_hold[%0d]: we=%b addr=%h data=%h, required 1/0000/48",
                 i, bus.char_we, bus.char_addr, bus.char_data);
      end
      tick();
    end
    bus.char_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.char_we !== 1'b1) begin
        bad++;
        $display("FAIL no_bubble[%0d]: char_we=%b, required 1", i, bus.char_we);
      end
      tick();
    end
    total++;
    if (bus.char_we !== 1'b0 || bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL b2b_end: we=%b empty=%b, required 0/1", bus.char_we, bus.empty);
    end
    wait_drain();
  endtask

  task automatic test_full();
    bus.char_ready = 1'b0;
    for (int k = 0; k < 8; k++)
      push_store(13'h0100 + 13'(4 * k), 32'h44434241 + 32'h04040404 * 32'(k), SIZE_WORD);
    total++;
    if (bus.in_ready !== 1'b0 || bus.count !== 4'd8) begin
      bad++;
      $display("FAIL full_flag: in_ready=%b count=%0d, required 0/8", bus.in_ready, bus.count);
    end
    bus.in_valid = 1'b1;
    bus.in_addr  = 13'h0200;
    bus.in_data  = 32'h5A5A5A5A;
    bus.in_size  = SIZE_WORD;
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (bus.count !== 4'd8) begin
      bad++;
      $display("FAIL full_reject: count=%0d, required 8", bus.count);
    end
    bus.char_ready = 1'b1;
    repeat (3) tick();
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_early_ready: in_ready=%b after 3 beats, required 0", bus.in_ready);
    end
    tick();
    total++;
    if (bus.in_ready !== 1'b1 || bus.count !== 4'd7) begin
      bad++;
      $display("FAIL full_release: in_ready=%b count=%0d, required 1/7", bus.in_ready, bus.count);
    end
    wait_drain();
  endtask

  task automatic test_range();
    bus.char_ready = 1'b1;
    push_store(13'd4798, 32'h5A595857, SIZE_WORD);
    wait_drain();
    total++;
    if (bus.range_error !== exp_range_err || bus.range_error !== 1'b1) begin
      bad++;
      $display("FAIL range_set: range_error=%b, required 1", bus.range_error);
    end
    // Out-of-range beats drain without any char_ready.
    bus.char_ready = 1'b0;
    push_store(13'd4800, 32'h00004241, SIZE_HALF);
    wait_drain();
    // Wrap past the top of the address space lands back in range.
    bus.char_ready = 1'b1;
    push_store(13'h1FFF, 32'h64636261, SIZE_WORD);
    wait_drain();
    push_store(13'h0005, 32'h00000021, SIZE_BYTE);
    wait_drain();
    total++;
    if (bus.range_error !== 1'b1) begin
      bad++;
      $display("FAIL range_sticky: range_error=%b, required 1", bus.range_error);
    end
    apply_reset();
    total++;
    if (bus.range_error !== 1'b0) begin
      bad++;
      $display("FAIL range_clear: range_error=%b, required 0", bus.range_error);
    end
  endtask

  task automatic test_size_none();
    bus.char_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_addr  = 13'h0030;
    bus.in_data  = 32'h31313131;
    bus.in_size  = SIZE_NONE;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.count !== 4'd0 || bus.char_we !== 1'b0 || bus.empty !== 1'b1) begin
        bad++;
        $display("FAIL size_none[%0d]: count=%0d we=%b empty=%b, required 0/0/1",
                 i, bus.count, bus.char_we, bus.empty);
      end
      tick();
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    exp_range_err  = 1'b0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_addr    = '0;
    bus.in_data    = '0;
    bus.in_size    = SIZE_NONE;
    bus.char_ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_full();
    test_range();
    test_size_none();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
